// File: rtl/pulse_train_generator.sv
// Burst pulse-train source for the time-to-digital input: NUM_PULSES pulses of
// programmable period and high time, latched once per burst in LOAD.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// LOAD  | one cycle: clamp and latch period/high time, clear counters
// HIGH  | pulse_out=1 for H cycles
// LOW   | pulse_out=0 for P-H cycles, pulse_index bumps on exit
// DONE  | one-cycle done strobe, then back to IDLE
module pulse_train_generator #(
    parameter int NUM_PULSES      = 10,
    parameter int COUNT_TIME_BITS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [COUNT_TIME_BITS-1:0] period,
    input  logic [COUNT_TIME_BITS-1:0] high_cycles,
    output logic                       pulse_out,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [15:0]                pulse_index
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [COUNT_TIME_BITS-1:0] CNT_ONE  = {{(COUNT_TIME_BITS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_TIME_BITS-1:0] CNT_TWO  = CNT_ONE << 1;
    localparam logic [15:0]                LAST_IDX = 16'(NUM_PULSES);

    state_t                     state;
    logic [COUNT_TIME_BITS-1:0] phase_cnt;
    logic [COUNT_TIME_BITS-1:0] high_term;
    logic [COUNT_TIME_BITS-1:0] low_term;
    logic [COUNT_TIME_BITS-1:0] p_clamp;
    logic [COUNT_TIME_BITS-1:0] h_clamp;
    logic [15:0]                index_inc;

    // H is bounded by P-1 so the low phase is never empty and the counters cannot wrap.
    always_comb begin
        p_clamp = (period < CNT_TWO) ? CNT_TWO : period;
        if (high_cycles == '0)
            h_clamp = CNT_ONE;
        else if (high_cycles >= p_clamp)
            h_clamp = p_clamp - CNT_ONE;
        else
            h_clamp = high_cycles;
    end

    assign index_inc = pulse_index + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pulse_out   <= 1'b0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_index <= '0;
            phase_cnt   <= '0;
            high_term   <= '0;
            low_term    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        pulse_out <= 1'b0;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        // Terminal counts stored as length-1 so each phase compares directly.
                        high_term   <= h_clamp - CNT_ONE;
                        low_term    <= p_clamp - h_clamp - CNT_ONE;
                        phase_cnt   <= '0;
                        pulse_index <= '0;
                        state       <= ST_HIGH;
                        pulse_out   <= 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        pulse_out <= 1'b0;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        phase_cnt <= '0;
                    end else if (phase_cnt == high_term) begin
                        state     <= ST_LOW;
                        pulse_out <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end

                ST_LOW: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        pulse_out <= 1'b0;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        phase_cnt <= '0;
                    end else if (phase_cnt == low_term) begin
                        pulse_index <= index_inc;
                        phase_cnt   <= '0;
                        if (index_inc < LAST_IDX) begin
                            state     <= ST_HIGH;
                            pulse_out <= 1'b1;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + CNT_ONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    pulse_out <= 1'b0;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Scoreboard bench for pulse_train_generator: stimulus queues expected edge/strobe
// events with their cycle numbers, a negedge monitor pops and compares them.
module tb_pulse_train_generator;

    localparam int EV_RISE = 0;
    localparam int EV_FALL = 1;
    localparam int EV_DONE = 2;
    localparam int EV_RDY  = 3;

    typedef struct {
        int kind;
        int cyc;
        int data;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] period;
    logic [15:0] high_cycles;
    logic        pulse_out;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] pulse_index;

    int  cyc = 0;
    int  chk_cnt = 0;
    int  pass_cnt = 0;
    ev_t exp_q[$];
    logic prev_pulse = 1'b0;
    logic prev_ready = 1'b1;

    pulse_train_generator #(
        .NUM_PULSES      (10),
        .COUNT_TIME_BITS (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .period      (period),
        .high_cycles (high_cycles),
        .pulse_out   (pulse_out),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .pulse_index (pulse_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_RISE: return "rise";
            EV_FALL: return "fall";
            EV_DONE: return "done";
            default: return "ready";
        endcase
    endfunction

    task automatic push_ev(input int k, input int c, input int d);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic plan_burst(input int r0, input int p, input int h);
        for (int i = 0; i < 10; i++) begin
            push_ev(EV_RISE, r0 + i * p, 0);
            push_ev(EV_FALL, r0 + i * p + h, 0);
        end
        push_ev(EV_DONE, r0 + 10 * p, 10);
        push_ev(EV_RDY, r0 + 10 * p + 1, 10);
    endtask

    task automatic check_ev(input int k, input int c, input int d);
        ev_t e;
        chk_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got %s at cycle %0d data %0d, required no event",
                     ev_name(k), c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == c && e.data == d)
                pass_cnt++;
            else
                $display("FAIL event_%s: got %s at cycle %0d data %0d, required %s at cycle %0d data %0d",
                         ev_name(e.kind), ev_name(k), c, d, ev_name(e.kind), e.cyc, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (pulse_out && !prev_pulse) check_ev(EV_RISE, cyc, 0);
        if (!pulse_out && prev_pulse) check_ev(EV_FALL, cyc, 0);
        if (done) check_ev(EV_DONE, cyc, int'(pulse_index));
        if (ready && !prev_ready) check_ev(EV_RDY, cyc, int'(pulse_index));
        prev_pulse = pulse_out;
        prev_ready = ready;
    end

    task automatic chk(input string name, input int got, input int req);
        chk_cnt++;
        if (got == req)
            pass_cnt++;
        else
            $display("FAIL %s: got %0d, required %0d", name, got, req);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) @(negedge clk);
        #1;
    endtask

    task automatic start_burst(output int s);
        step();
        s = cyc + 1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk_cnt++;
        if (exp_q.size() == 0) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s_drain: got %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish by 100000 ns, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int r0;
        int d;
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        period      = 16'd10;
        high_cycles = 16'd3;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", int'(ready), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pulse", int'(pulse_out), 0);
        chk("reset_index", int'(pulse_index), 0);
        rst = 1'b1;

        // nominal 10 x (P=10, H=3)
        start_burst(s);
        plan_burst(s + 1, 10, 3);
        chk("nominal_busy", int'(busy), 1);
        wait_drain("nominal", 300);
        chk("nominal_index", int'(pulse_index), 10);

        // clamping: 0/0 -> P=2,H=1 ; 5/9 -> P=5,H=4
        period = 16'd0;
        high_cycles = 16'd0;
        start_burst(s);
        plan_burst(s + 1, 2, 1);
        wait_drain("clamp_zero", 100);

        period = 16'd5;
        high_cycles = 16'd9;
        start_burst(s);
        plan_burst(s + 1, 5, 4);
        wait_drain("clamp_high", 150);

        // inputs changed and start pulsed mid-burst
        period = 16'd10;
        high_cycles = 16'd3;
        start_burst(s);
        plan_burst(s + 1, 10, 3);
        goto_cyc(s + 16);
        period = 16'd3;
        high_cycles = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_drain("midburst", 300);
        period = 16'd10;
        high_cycles = 16'd3;

        // back-to-back with start held
        step();
        s = cyc + 1;
        start = 1'b1;
        d = s + 101;
        plan_burst(s + 1, 10, 3);
        plan_burst(d + 3, 10, 3);
        goto_cyc(d + 2);
        start = 1'b0;
        wait_drain("back_to_back", 400);

        // abort during the fourth pulse's high phase
        start_burst(s);
        r0 = s + 1;
        for (int i = 0; i < 3; i++) begin
            push_ev(EV_RISE, r0 + i * 10, 0);
            push_ev(EV_FALL, r0 + i * 10 + 3, 0);
        end
        push_ev(EV_RISE, r0 + 30, 0);
        push_ev(EV_FALL, r0 + 31, 0);
        push_ev(EV_RDY, r0 + 31, 3);
        goto_cyc(r0 + 30);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_pulse", int'(pulse_out), 0);
        wait_drain("abort", 100);
        repeat (3) step();
        chk("abort_index", int'(pulse_index), 3);
        chk("abort_busy", int'(busy), 0);

        // start and abort together in IDLE: start wins
        step();
        s = cyc + 1;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        plan_burst(s + 1, 10, 3);
        wait_drain("start_abort", 300);

        // asynchronous reset between edges while high
        start_burst(s);
        r0 = s + 1;
        push_ev(EV_RISE, r0, 0);
        push_ev(EV_FALL, r0 + 3, 0);
        push_ev(EV_RISE, r0 + 10, 0);
        push_ev(EV_FALL, r0 + 11, 0);
        push_ev(EV_RDY, r0 + 11, 0);
        goto_cyc(r0 + 10);
        chk("pre_reset_pulse", int'(pulse_out), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_pulse", int'(pulse_out), 0);
        chk("async_reset_index", int'(pulse_index), 0);
        step();
        rst = 1'b1;
        step();
        chk("post_reset_ready", int'(ready), 1);
        chk("post_reset_busy", int'(busy), 0);
        wait_drain("async_reset", 50);

        repeat (5) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 SHALL have parameter NUM_PULSES, default 10: number of pulses per burst, range 1..2^16-1.
REQ-002 SHALL have parameter COUNT_TIME_BITS, default 16: width of the period and high-time fields.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: synchronous burst cancel.
REQ-007 SHALL have port period, input, COUNT_TIME_BITS bits: clk cycles from one pulse rising edge to the next.
REQ-008 SHALL have port high_cycles, input, COUNT_TIME_BITS bits: clk cycles pulse_out stays high.
REQ-009 SHALL have port pulse_out, output, 1 bit: registered pulse train driven to the time-to-digital input.
REQ-010 SHALL have port ready, output, 1 bit: high when state is IDLE.
REQ-011 SHALL have port busy, output, 1 bit: high in LOAD, HIGH and LOW.
REQ-012 SHALL have port done, output, 1 bit: one-cycle strobe on burst completion.
REQ-013 SHALL have port pulse_index, output, 16 bits: number of pulses completed in the current burst.

Function
REQ-014 SHALL implement exactly five states:
- IDLE
- LOAD
- HIGH
- LOW
- DONE
Any other encoding SHALL go to IDLE on the next edge.
REQ-015 IDLE SHALL go to LOAD on an edge where start=1; otherwise it SHALL hold.
REQ-016 LOAD SHALL last one cycle and SHALL latch the effective period P and effective high time H from the period and high_cycles inputs.
REQ-017 LOAD SHALL also clear the phase counter and pulse_index, then go to HIGH.
REQ-018 Clamping SHALL be applied in LOAD:
- P = max(period, 2)
- H = 1 if high_cycles = 0
- H = P-1 if high_cycles >= P
- otherwise H = high_cycles
REQ-019 period and high_cycles SHALL be ignored outside LOAD; a mid-burst change SHALL NOT affect the burst.
REQ-020 HIGH SHALL last exactly H cycles with pulse_out=1, then go to LOW.
REQ-021 LOW SHALL last exactly P-H cycles with pulse_out=0.
REQ-022 pulse_index SHALL increment by 1 on the edge that leaves LOW.
REQ-023 On leaving LOW, the next state SHALL be HIGH if the incremented pulse_index < NUM_PULSES, else DONE.
REQ-024 DONE SHALL last one cycle with done=1 and pulse_out=0, then go to IDLE; pulse_index SHALL hold NUM_PULSES until the next LOAD.
REQ-025 pulse_out SHALL be a flop output, glitch-free, high only in HIGH.
REQ-026 Latency: pulse_out SHALL rise 2 clk edges after the edge sampling start=1 (the edge entering HIGH).
REQ-027 Rising edges of pulse_out SHALL be exactly P cycles apart; a burst SHALL span NUM_PULSES*P cycles from the first rise to the DONE entry.
REQ-028 start SHALL be ignored while not in IDLE; no queuing.
REQ-029 abort=1 in LOAD, HIGH or LOW SHALL force IDLE on the next edge, pulse_out=0, with no done strobe; pulse_index SHALL hold its value.
REQ-030 abort SHALL have no effect in IDLE or DONE.
REQ-031 If abort and start are both high in IDLE, start SHALL win.
REQ-032 Phase counters SHALL be COUNT_TIME_BITS wide and SHALL never wrap within a phase.
REQ-033 Consecutive bursts SHALL be possible with start held high: DONE -> IDLE -> LOAD, with at least 2 idle cycles of pulse_out=0 between bursts.

Reset
REQ-034 rst=0 SHALL asynchronously force:
- state = IDLE
- pulse_out = 0
- done = 0
- busy = 0
- ready = 1
- pulse_index = 0
- all counters = 0
REQ-035 Reset mid-burst SHALL drop pulse_out within the same cycle, with no done strobe.
REQ-036 Release of reset SHALL be synchronized externally; the first active edge SHALL see state IDLE.

Verification
REQ-037 Nominal burst: period=10, high_cycles=3, NUM_PULSES=10, one-cycle start -> 10 pulses, each 3 cycles high; rises 10 cycles apart; first rise 2 edges after start; done 100 cycles after the first rise; pulse_index=10.
REQ-038 Clamping:
- period=0, high_cycles=0 -> period 2, 1 cycle high
- period=5, high_cycles=9 -> 4 cycles high, 1 cycle low
REQ-039 Mid-burst abort: abort asserted during pulse 4 HIGH -> pulse_out=0 and ready=1 on the next edge; done never asserted; pulse_index=3.
REQ-040 Asynchronous reset: rst=0 between edges during HIGH -> pulse_out=0 immediately; after release ready=1 and pulse_index=0.
REQ-041 Start ignored and inputs stable: start pulsed while busy, and period changed mid-burst -> no restart, spacing stays at the latched P; start held high -> back-to-back bursts with a 2-cycle gap.
